// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encodings,
// ALUOp/ALUControl codes, opcodes and datapath mux-select codes.
package multicycle_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction funct fields to an ALUControl code.
module multicycle_controller_alu_dec
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) with funct7_5 selects sub; addi ignores IR[30].
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalInstr,
  output logic       InstrDone
);

  state_t  state_reg, state_next;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;
  logic    mem_ready;

`ifdef MC_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  logic unused_mem_ready;
  assign mem_ready        = 1'b1;
  assign unused_mem_ready = MemReady;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc       = ADR_PC;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;
    InstrDone    = 1'b0;
    alu_op       = ALUOP_ADD;
    pc_update    = 1'b0;
    branch       = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          IRWrite   = mem_ready;
          pc_update = mem_ready;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_IMM;
          IllegalInstr = !op_supported(op);
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: AdrSrc = ADR_ALUOUT;
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc    = ADR_ALUOUT;
          MemWrite  = 1'b1;
          InstrDone = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_RD2;
          alu_op  = ALUOP_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          alu_op  = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_RD2;
          alu_op    = ALUOP_SUB;
          ResultSrc = RES_ALUOUT;
          branch    = 1'b1;
          InstrDone = 1'b1;
        end
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALUOUT;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
    PCWrite = pc_update | (branch & zero);
  end

  assign ImmSrc = reset ? IMM_I : imm_src_of(op);

  multicycle_controller_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

endmodule
